snake_head_ctl: RTL and testbench

//  Game-step scheduler for the snake playfield drawn by the background stage.

---
 rtl/snake_pkg.sv | 12 +
 rtl/snake_tick_gen.sv | 31 +++
 rtl/snake_head_ctl.sv | 107 ++++++++++
 tb/tb_snake_head_ctl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: direction/state encodings, playfield bounds and start position shared with draw stages.
package snake_pkg;
    typedef enum logic [1:0] {DIR_RIGHT = 2'd0, DIR_UP = 2'd1, DIR_LEFT = 2'd2, DIR_DOWN = 2'd3} dir_t;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_OVER = 2'd2} state_t;
    localparam int GRID_X_MIN   = 13;
    localparam int GRID_X_MAX   = 50;
    localparam int GRID_Y_MIN   = 15;
    localparam int GRID_Y_MAX   = 32;
    localparam int GRID_X_START = 31;
    localparam int GRID_Y_START = 23;
    localparam int TICK_FRAMES_DEF = 8;
endpackage

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: vsync rising-edge detect and frame divider producing a 1-cycle step_tick.
module snake_tick_gen #(
    parameter int TICK_FRAMES = 8
) (
    input  logic pclk,
    input  logic rst,
    input  logic vsync_in,
    input  logic en,
    input  logic clr,
    output logic step_tick
);
    localparam int CW = TICK_FRAMES > 1 ? $clog2(TICK_FRAMES) : 1;
    logic          vs_d;
    logic [CW-1:0] cnt;
    logic          tick, last;
    assign tick      = vsync_in & ~vs_d;
    assign last      = cnt == CW'(TICK_FRAMES - 1);
    assign step_tick = en & tick & last;
    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_d <= 1'b0;
            cnt  <= '0;
        end else begin
            vs_d <= vsync_in;
            if (clr)
                cnt <= '0;
            else if (en && tick)
                cnt <= last ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/snake_head_ctl.sv
// snake_head_ctl: game FSM, direction filter and head datapath stepped once per TICK_FRAMES frames.
// Define SNAKE_WRAP_EN to make walls wrap around instead of ending the game.
module snake_head_ctl
    import snake_pkg::*;
#(
    parameter int TICK_FRAMES = TICK_FRAMES_DEF,
    parameter int X_MIN       = GRID_X_MIN,
    parameter int X_MAX       = GRID_X_MAX,
    parameter int Y_MIN       = GRID_Y_MIN,
    parameter int Y_MAX       = GRID_Y_MAX,
    parameter int X_START     = GRID_X_START,
    parameter int Y_START     = GRID_Y_START
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        start,
    input  logic        dir_valid,
    input  logic [1:0]  dir_req,
    output logic [9:0]  head_x_grid,
    output logic [9:0]  head_y_grid,
    output logic [1:0]  dir_out,
    output logic        step_strobe,
    output logic        game_over,
    output logic [1:0]  state_out,
    output logic [15:0] move_cnt
);
    state_t      state, state_n;
    dir_t        dir, dir_n, pend, pend_n;
    logic [9:0]  hx, hy, hx_n, hy_n, nx, ny, wx, wy;
    logic [15:0] mc, mc_n;
    logic        strobe_n, step_tick, go, ok;
    assign go = start & (state != ST_RUN);
    snake_tick_gen #(.TICK_FRAMES(TICK_FRAMES)) u_tick (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in),
        .en(state == ST_RUN), .clr(go), .step_tick(step_tick)
    );
    // Candidate next head; moving left/up from 0 wraps to 1023, which is out of range anyway.
    assign nx = pend == DIR_RIGHT ? hx + 10'd1 : pend == DIR_LEFT ? hx - 10'd1 : hx;
    assign ny = pend == DIR_DOWN  ? hy + 10'd1 : pend == DIR_UP   ? hy - 10'd1 : hy;
`ifdef SNAKE_WRAP_EN
    assign wx = nx > 10'(X_MAX) ? 10'(X_MIN) : nx < 10'(X_MIN) ? 10'(X_MAX) : nx;
    assign wy = ny > 10'(Y_MAX) ? 10'(Y_MIN) : ny < 10'(Y_MIN) ? 10'(Y_MAX) : ny;
    assign ok = 1'b1;
`else
    assign wx = nx;
    assign wy = ny;
    assign ok = nx >= 10'(X_MIN) && nx <= 10'(X_MAX) && ny >= 10'(Y_MIN) && ny <= 10'(Y_MAX);
`endif
    always_comb begin
        state_n  = state;
        dir_n    = dir;
        pend_n   = pend;
        hx_n     = hx;
        hy_n     = hy;
        mc_n     = mc;
        strobe_n = 1'b0;
        if (go) begin
            state_n = ST_RUN;
            dir_n   = DIR_RIGHT;
            pend_n  = DIR_RIGHT;
            hx_n    = 10'(X_START);
            hy_n    = 10'(Y_START);
            mc_n    = '0;
        end else if (state == ST_RUN) begin
            // Requests are filtered against the committed direction, not the pending one.
            if (dir_valid && dir_req != (dir ^ 2'd2))
                pend_n = dir_t'(dir_req);
            if (step_tick) begin
                dir_n = pend;
                if (ok) begin
                    hx_n     = wx;
                    hy_n     = wy;
                    strobe_n = 1'b1;
                    mc_n     = mc == 16'hFFFF ? mc : mc + 16'd1;
                end else begin
                    state_n = ST_OVER;
                end
            end
        end
    end
    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= ST_IDLE;
            dir         <= DIR_RIGHT;
            pend        <= DIR_RIGHT;
            hx          <= 10'(X_START);
            hy          <= 10'(Y_START);
            mc          <= '0;
            step_strobe <= 1'b0;
        end else begin
            state       <= state_n;
            dir         <= dir_n;
            pend        <= pend_n;
            hx          <= hx_n;
            hy          <= hy_n;
            mc          <= mc_n;
            step_strobe <= strobe_n;
        end
    end
    assign head_x_grid = hx;
    assign head_y_grid = hy;
    assign dir_out     = dir;
    assign state_out   = state;
    assign game_over   = state == ST_OVER;
    assign move_cnt    = mc;
endmodule

// File: tb/tb_snake_head_ctl.sv
// tb_snake_head_ctl: directed steps with a step scoreboard; main DUT at TICK_FRAMES=8, second at 1.
module tb_snake_head_ctl;
    logic        pclk = 1'b0;
    logic        rst = 1'b1, vsync_in = 1'b0, start = 1'b0, dir_valid = 1'b0;
    logic [1:0]  dir_req = 2'd0;
    logic [9:0]  hx, hy, hx1, hy1;
    logic [1:0]  dir, dir1, st, st1;
    logic        strobe, strobe1, go, go1;
    logic [15:0] mc, mc1;
    int          total = 0, bad = 0;
    logic [19:0] q[$];

    always #5 pclk = ~pclk;

    snake_head_ctl u0 (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start),
        .dir_valid(dir_valid), .dir_req(dir_req),
        .head_x_grid(hx), .head_y_grid(hy), .dir_out(dir), .step_strobe(strobe),
        .game_over(go), .state_out(st), .move_cnt(mc)
    );
    snake_head_ctl #(.TICK_FRAMES(1)) u1 (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start),
        .dir_valid(dir_valid), .dir_req(dir_req),
        .head_x_grid(hx1), .head_y_grid(hy1), .dir_out(dir1), .step_strobe(strobe1),
        .game_over(go1), .state_out(st1), .move_cnt(mc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Each step_strobe of the main DUT must match the next expected head position.
    always @(negedge pclk) begin
        if (strobe) begin
            logic [19:0] e;
            e = q.size() != 0 ? q.pop_front() : 20'hFFFFF;
            chk("step_head", {hx, hy}, e);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic vs();
        vsync_in = 1'b1;
        cyc(1);
        vsync_in = 1'b0;
        cyc(2);
    endtask

    task automatic step();
        repeat (8) vs();
    endtask

    task automatic push(input int x, input int y);
        q.push_back({10'(x), 10'(y)});
    endtask

    task automatic req(input logic [1:0] d);
        dir_valid = 1'b1;
        dir_req   = d;
        cyc(1);
        dir_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic head(input string tag, input int x, input int y);
        chk(tag, {hx, hy}, {10'(x), 10'(y)});
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        chk("rst_state", st, 0);
        head("rst_head", 31, 23);
        chk("rst_dir", dir, 0);
        chk("rst_mc", mc, 0);
        chk("rst_go", go, 0);
        chk("rst_strobe", strobe, 0);
        vs();
        chk("idle_ignores_tick", {st, hx}, {2'd0, 10'd31});

        do_start();
        chk("start_run", st, 1);
        push(32, 23);
        vs();
        chk("tf1_head", {hx1, hy1}, {10'd32, 10'd23});
        repeat (7) vs();
        head("t1_head", 32, 23);
        chk("t1_mc", mc, 1);
        chk("t1_dir", dir, 0);
        chk("t1_queue", q.size(), 0);
        chk("tf1_head8", {hx1, hy1}, {10'd39, 10'd23});
        chk("tf1_mc8", mc1, 8);

        req(2'd2);
        push(33, 23);
        step();
        head("t2_reverse_dropped", 33, 23);
        chk("t2_dir_right", dir, 0);
        req(2'd1);
        push(33, 22);
        step();
        head("t2_up_head", 33, 22);
        chk("t2_dir_up", dir, 1);

        req(2'd0);
        push(34, 22);
        step();
        repeat (7) vs();
        vsync_in  = 1'b1;
        dir_valid = 1'b1;
        dir_req   = 2'd1;
        push(35, 22);
        push(35, 21);
        cyc(1);
        vsync_in  = 1'b0;
        dir_valid = 1'b0;
        chk("t4_dir_same_edge", dir, 0);
        head("t4_moved_right", 35, 22);
        cyc(2);
        step();
        head("t4_next_up", 35, 21);
        chk("t4_dir_up", dir, 1);
        chk("t4_mc", mc, 6);

        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t5_state", st, 0);
        head("t5_head", 31, 23);
        chk("t5_mc", mc, 0);
        chk("t5_dir", dir, 0);
        step();
        head("t5_ticks_ignored", 31, 23);

        do_start();
        for (int i = 1; i <= 19; i++) begin
            push(31 + i, 23);
            step();
        end
        head("t3_at_wall", 50, 23);
        chk("t3_mc19", mc, 19);
`ifdef SNAKE_WRAP_EN
        push(13, 23);
        step();
        head("t3_wrap_head", 13, 23);
        chk("t3_wrap_go", go, 0);
        chk("t3_wrap_mc", mc, 20);
        do_start();
        chk("t6_start_ignored", mc, 20);
`else
        step();
        chk("t3_go", go, 1);
        chk("t3_state", st, 2);
        head("t3_head_hold", 50, 23);
        chk("t3_mc_hold", mc, 19);
        step();
        head("t6_over_hold", 50, 23);
        do_start();
        chk("t6_state", st, 1);
        head("t6_head", 31, 23);
        chk("t6_go", go, 0);
        chk("t6_mc", mc, 0);
        chk("t6_tf1_state", st1, 1);
        vs();
        chk("t6_tf1_step", {hx1, hy1}, {10'd32, 10'd23});
        head("t6_no_step_yet", 31, 23);
`endif
        cyc(2);
        chk("final_queue", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
